// File: rtl/serial_frame.sv
// Framed serial bridge: UART bytes <-> channel-tagged WIDTH-bit reward/action words.
// Optional trailing XOR checksum byte enabled by defining SERIAL_FRAME_CHECKSUM_EN.
module serial_frame #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int TIMEOUT  = 120000,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_stb,
    input  logic [7:0]       rx_dat,
    output logic             rx_rdy,
    output logic             reward_valid,
    output logic [CW-1:0]    reward_channel,
    output logic [WIDTH-1:0] reward_data,
    input  logic             reward_ready,
    input  logic             action_valid,
    input  logic [CW-1:0]    action_channel,
    input  logic [WIDTH-1:0] action_data,
    output logic             action_ready,
    output logic             tx_stb,
    output logic [7:0]       tx_dat,
    input  logic             tx_rdy,
    output logic             err
);

    localparam int BYTES = WIDTH / 8;
`ifdef SERIAL_FRAME_CHECKSUM_EN
    localparam int DROP_LEN = BYTES + 1;
`else
    localparam int DROP_LEN = BYTES;
`endif
    localparam int BCW = $clog2(BYTES + 2);
    localparam int TCW = $clog2(TIMEOUT + 1);

    localparam logic [BCW-1:0] LAST_DATA = BCW'(BYTES - 1);
    localparam logic [BCW-1:0] LAST_DROP = BCW'(DROP_LEN - 1);
    localparam logic [TCW-1:0] IDLE_LIM  = TCW'(TIMEOUT - 1);
    localparam logic [8:0]     CHAN_LIM  = 9'(CHANNELS);

`ifdef SERIAL_FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {RX_HEAD, RX_DATA, RX_CHECK, RX_DROP, RX_HOLD} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_DATA, TX_CHECK} tx_state_t;
`else
    typedef enum logic [2:0] {RX_HEAD, RX_DATA, RX_DROP, RX_HOLD} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_DATA} tx_state_t;
`endif

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    rx_state_t        rx_state_reg, rx_state_next;
    logic             rx_rdy_reg;
    logic             reward_valid_reg;
    logic [CW-1:0]    reward_channel_reg;
    logic [WIDTH-1:0] reward_data_reg;
    logic [BCW-1:0]   rx_cnt_reg;
    logic [TCW-1:0]   idle_cnt_reg;
    logic             err_reg, err_next;
    logic [WIDTH-1:0] rx_shifted;
    logic             rx_acc;
    logic             rx_timing;
    logic             rx_timeout;
    logic             head_ok;
`ifdef SERIAL_FRAME_CHECKSUM_EN
    logic [7:0]       rx_csum_reg;
`endif

    assign rx_acc     = rx_stb && rx_rdy_reg;
    assign head_ok    = ({1'b0, rx_dat} < CHAN_LIM);
`ifdef SERIAL_FRAME_CHECKSUM_EN
    assign rx_timing  = (rx_state_reg == RX_DATA) || (rx_state_reg == RX_CHECK) ||
                        (rx_state_reg == RX_DROP);
`else
    assign rx_timing  = (rx_state_reg == RX_DATA) || (rx_state_reg == RX_DROP);
`endif
    // A byte accepted on the limit edge suppresses the timeout.
    assign rx_timeout = rx_timing && !rx_acc && (idle_cnt_reg == IDLE_LIM);

    generate
        if (BYTES > 1) begin : g_rx_shift_wide
            assign rx_shifted = {rx_dat, reward_data_reg[WIDTH-1:8]};
        end else begin : g_rx_shift_byte
            assign rx_shifted = rx_dat;
        end
    endgenerate

    always_comb begin
        rx_state_next = rx_state_reg;
        err_next      = 1'b0;
        case (rx_state_reg)
            RX_HEAD: begin
                if (rx_acc) begin
                    if (head_ok) begin
                        rx_state_next = RX_DATA;
                    end else begin
                        err_next      = 1'b1;
                        rx_state_next = RX_DROP;
                    end
                end
            end
            RX_DATA: begin
                if (rx_timeout) begin
                    err_next      = 1'b1;
                    rx_state_next = RX_HEAD;
                end else if (rx_acc && rx_cnt_reg == LAST_DATA) begin
`ifdef SERIAL_FRAME_CHECKSUM_EN
                    rx_state_next = RX_CHECK;
`else
                    rx_state_next = RX_HOLD;
`endif
                end
            end
`ifdef SERIAL_FRAME_CHECKSUM_EN
            RX_CHECK: begin
                if (rx_timeout) begin
                    err_next      = 1'b1;
                    rx_state_next = RX_HEAD;
                end else if (rx_acc) begin
                    if (rx_dat == rx_csum_reg) begin
                        rx_state_next = RX_HOLD;
                    end else begin
                        err_next      = 1'b1;
                        rx_state_next = RX_HEAD;
                    end
                end
            end
`endif
            RX_DROP: begin
                if (rx_timeout) begin
                    err_next      = 1'b1;
                    rx_state_next = RX_HEAD;
                end else if (rx_acc && rx_cnt_reg == LAST_DROP) begin
                    rx_state_next = RX_HEAD;
                end
            end
            RX_HOLD: begin
                if (reward_ready) begin
                    rx_state_next = RX_HEAD;
                end
            end
            default: rx_state_next = RX_HEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg       <= RX_HEAD;
            rx_rdy_reg         <= 1'b0;
            reward_valid_reg   <= 1'b0;
            reward_channel_reg <= '0;
            reward_data_reg    <= '0;
            rx_cnt_reg         <= '0;
            idle_cnt_reg       <= '0;
            err_reg            <= 1'b0;
`ifdef SERIAL_FRAME_CHECKSUM_EN
            rx_csum_reg        <= '0;
`endif
        end else begin
            rx_state_reg     <= rx_state_next;
            // Handshake flags follow the next state so they never depend on inputs combinationally.
            rx_rdy_reg       <= (rx_state_next != RX_HOLD);
            reward_valid_reg <= (rx_state_next == RX_HOLD);
            err_reg          <= err_next;

            if (rx_acc || !rx_timing || rx_timeout) begin
                idle_cnt_reg <= '0;
            end else begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end

            if (rx_acc) begin
                case (rx_state_reg)
                    RX_HEAD: begin
                        rx_cnt_reg <= '0;
`ifdef SERIAL_FRAME_CHECKSUM_EN
                        rx_csum_reg <= rx_dat;
`endif
                        if (head_ok) begin
                            reward_channel_reg <= rx_dat[CW-1:0];
                        end
                    end
                    RX_DATA: begin
                        reward_data_reg <= rx_shifted;
                        rx_cnt_reg      <= rx_cnt_reg + 1'b1;
`ifdef SERIAL_FRAME_CHECKSUM_EN
                        rx_csum_reg     <= rx_csum_reg ^ rx_dat;
`endif
                    end
                    RX_DROP: rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign rx_rdy         = rx_rdy_reg;
    assign reward_valid   = reward_valid_reg;
    assign reward_channel = reward_channel_reg;
    assign reward_data    = reward_data_reg;
    assign err            = err_reg;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    tx_state_t        tx_state_reg, tx_state_next;
    logic             action_ready_reg;
    logic             tx_stb_reg;
    logic [7:0]       tx_dat_reg;
    logic [WIDTH-1:0] tx_shift_reg;
    logic [WIDTH-1:0] tx_shifted;
    logic [BCW-1:0]   tx_cnt_reg;
    logic             act_acc;
    logic             tx_acc;
`ifdef SERIAL_FRAME_CHECKSUM_EN
    logic [7:0]       tx_csum_reg;
    logic [7:0]       act_xor [0:BYTES];

    assign act_xor[0] = 8'(action_channel);
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_act_xor
            assign act_xor[gi+1] = act_xor[gi] ^ action_data[8*gi +: 8];
        end
    endgenerate
`endif

    assign act_acc = action_valid && action_ready_reg;
    assign tx_acc  = tx_stb_reg && tx_rdy;

    generate
        if (BYTES > 1) begin : g_tx_shift_wide
            assign tx_shifted = {8'h00, tx_shift_reg[WIDTH-1:8]};
        end else begin : g_tx_shift_byte
            assign tx_shifted = '0;
        end
    endgenerate

    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            TX_IDLE: if (act_acc) tx_state_next = TX_HEAD;
            TX_HEAD: if (tx_acc) tx_state_next = TX_DATA;
            TX_DATA: begin
                if (tx_acc && tx_cnt_reg == LAST_DATA) begin
`ifdef SERIAL_FRAME_CHECKSUM_EN
                    tx_state_next = TX_CHECK;
`else
                    tx_state_next = TX_IDLE;
`endif
                end
            end
`ifdef SERIAL_FRAME_CHECKSUM_EN
            TX_CHECK: if (tx_acc) tx_state_next = TX_IDLE;
`endif
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg     <= TX_IDLE;
            action_ready_reg <= 1'b0;
            tx_stb_reg       <= 1'b0;
            tx_dat_reg       <= '0;
            tx_shift_reg     <= '0;
            tx_cnt_reg       <= '0;
`ifdef SERIAL_FRAME_CHECKSUM_EN
            tx_csum_reg      <= '0;
`endif
        end else begin
            tx_state_reg     <= tx_state_next;
            action_ready_reg <= (tx_state_next == TX_IDLE);
            tx_stb_reg       <= (tx_state_next != TX_IDLE);

            // tx_dat always holds the byte currently offered; it only moves on tx_acc.
            case (tx_state_reg)
                TX_IDLE: begin
                    if (act_acc) begin
                        tx_shift_reg <= action_data;
                        tx_dat_reg   <= 8'(action_channel);
`ifdef SERIAL_FRAME_CHECKSUM_EN
                        tx_csum_reg  <= act_xor[BYTES];
`endif
                    end
                end
                TX_HEAD: begin
                    if (tx_acc) begin
                        tx_dat_reg   <= tx_shift_reg[7:0];
                        tx_shift_reg <= tx_shifted;
                        tx_cnt_reg   <= '0;
                    end
                end
                TX_DATA: begin
                    if (tx_acc) begin
                        if (tx_cnt_reg != LAST_DATA) begin
                            tx_dat_reg   <= tx_shift_reg[7:0];
                            tx_shift_reg <= tx_shifted;
                            tx_cnt_reg   <= tx_cnt_reg + 1'b1;
                        end else begin
`ifdef SERIAL_FRAME_CHECKSUM_EN
                            tx_dat_reg <= tx_csum_reg;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign action_ready = action_ready_reg;
    assign tx_stb       = tx_stb_reg;
    assign tx_dat       = tx_dat_reg;

endmodule

// File: tb/tb_serial_frame.sv
// Directed self-checking bench for serial_frame (WIDTH=16, CHANNELS=4, short TIMEOUT).
// Checksum-specific steps are included when SERIAL_FRAME_CHECKSUM_EN is defined.
module tb_serial_frame;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_stb;
    logic [7:0]  rx_dat;
    logic        rx_rdy;
    logic        reward_valid;
    logic [1:0]  reward_channel;
    logic [15:0] reward_data;
    logic        reward_ready;
    logic        action_valid;
    logic [1:0]  action_channel;
    logic [15:0] action_data;
    logic        action_ready;
    logic        tx_stb;
    logic [7:0]  tx_dat;
    logic        tx_rdy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int valid_cnt = 0;
    int base_err;
    int base_valid;

    always #5 clk = ~clk;

    serial_frame #(.WIDTH(16), .CHANNELS(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .rx_stb(rx_stb), .rx_dat(rx_dat), .rx_rdy(rx_rdy),
        .reward_valid(reward_valid), .reward_channel(reward_channel),
        .reward_data(reward_data), .reward_ready(reward_ready),
        .action_valid(action_valid), .action_channel(action_channel),
        .action_data(action_data), .action_ready(action_ready),
        .tx_stb(tx_stb), .tx_dat(tx_dat), .tx_rdy(tx_rdy),
        .err(err)
    );

    always @(negedge clk) begin
        if (err) err_cnt <= err_cnt + 1;
        if (reward_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   budget;
        logic rdy;
        budget = 0;
        rx_stb = 1'b1;
        rx_dat = b;
        do begin
            rdy = rx_rdy;
            tick();
            budget++;
        end while (!rdy && budget < 200);
        check("rx_byte_accepted", 32'(rdy), 32'd1);
        rx_stb = 1'b0;
        rx_dat = 8'h00;
    endtask

    task automatic rx_frame(input logic [7:0] ch, input logic [15:0] d);
        send_byte(ch);
        send_byte(d[7:0]);
        send_byte(d[15:8]);
`ifdef SERIAL_FRAME_CHECKSUM_EN
        send_byte(ch ^ d[7:0] ^ d[15:8]);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rx_stb = 1'b0; rx_dat = 8'h00; reward_ready = 1'b0;
        action_valid = 1'b0; action_channel = 2'd0; action_data = 16'h0000;
        tx_rdy = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_rx_rdy", 32'(rx_rdy), 32'd0);
        check("rst_reward_valid", 32'(reward_valid), 32'd0);
        check("rst_reward_channel", 32'(reward_channel), 32'd0);
        check("rst_reward_data", 32'(reward_data), 32'd0);
        check("rst_action_ready", 32'(action_ready), 32'd0);
        check("rst_tx_stb", 32'(tx_stb), 32'd0);
        check("rst_tx_dat", 32'(tx_dat), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_rx_rdy", 32'(rx_rdy), 32'd1);
        check("post_rst_action_ready", 32'(action_ready), 32'd1);

        // Basic rx frame
        reward_ready = 1'b1;
        base_err = err_cnt;
        rx_frame(8'h02, 16'h1234);
        check("rx1_valid", 32'(reward_valid), 32'd1);
        check("rx1_channel", 32'(reward_channel), 32'd2);
        check("rx1_data", 32'(reward_data), 32'h1234);
        check("rx1_rdy_low", 32'(rx_rdy), 32'd0);
        tick();
        check("rx1_valid_one_cycle", 32'(reward_valid), 32'd0);
        check("rx1_rearm", 32'(rx_rdy), 32'd1);
        check("rx1_no_err", 32'(err_cnt - base_err), 32'd0);

        // Basic tx frame followed by a back-to-back frame with a stall
        tx_rdy = 1'b1;
        action_valid = 1'b1; action_channel = 2'd1; action_data = 16'hBEEF;
        tick();
        action_valid = 1'b0;
        check("tx1_busy", 32'(action_ready), 32'd0);
        check("tx1_stb_head", 32'(tx_stb), 32'd1);
        check("tx1_head", 32'(tx_dat), 32'h01);
        tick();
        check("tx1_stb_b0", 32'(tx_stb), 32'd1);
        check("tx1_b0", 32'(tx_dat), 32'hEF);
        tick();
        check("tx1_stb_b1", 32'(tx_stb), 32'd1);
        check("tx1_b1", 32'(tx_dat), 32'hBE);
`ifdef SERIAL_FRAME_CHECKSUM_EN
        tick();
        check("tx1_stb_ck", 32'(tx_stb), 32'd1);
        check("tx1_ck", 32'(tx_dat), 32'h50);
`endif
        tick();
        check("tx1_done_stb", 32'(tx_stb), 32'd0);
        check("tx1_idle_ready", 32'(action_ready), 32'd1);
        action_valid = 1'b1; action_channel = 2'd3; action_data = 16'h5A0F;
        tick();
        action_valid = 1'b0;
        tx_rdy = 1'b0;
        check("tx2_head", 32'(tx_dat), 32'h03);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tx2_stall_stb", 32'(tx_stb), 32'd1);
            check("tx2_stall_dat", 32'(tx_dat), 32'h03);
        end
        tx_rdy = 1'b1;
        tick();
        check("tx2_b0", 32'(tx_dat), 32'h0F);
        tick();
        check("tx2_b1", 32'(tx_dat), 32'h5A);
`ifdef SERIAL_FRAME_CHECKSUM_EN
        tick();
        check("tx2_ck", 32'(tx_dat), 32'h56);
`endif
        tick();
        check("tx2_done_stb", 32'(tx_stb), 32'd0);

        // Bad header: err pulse, drop rest of frame, then resync
        base_valid = valid_cnt;
        send_byte(8'h07);
        check("badhdr_err", 32'(err), 32'd1);
        tick();
        check("badhdr_err_pulse", 32'(err), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef SERIAL_FRAME_CHECKSUM_EN
        send_byte(8'h00);
`endif
        check("badhdr_no_valid", 32'(valid_cnt - base_valid), 32'd0);
        rx_frame(8'h00, 16'hABCD);
        check("badhdr_next_valid", 32'(reward_valid), 32'd1);
        check("badhdr_next_channel", 32'(reward_channel), 32'd0);
        check("badhdr_next_data", 32'(reward_data), 32'hABCD);
        tick();

        // Inter-byte timeout
        base_valid = valid_cnt;
        send_byte(8'h00);
        send_byte(8'hAA);
        base_err = err_cnt;
        repeat (TO - 1) tick();
        check("to_not_yet", 32'(err), 32'd0);
        tick();
        check("to_err", 32'(err), 32'd1);
        tick();
        check("to_err_pulse", 32'(err), 32'd0);
        check("to_err_count", 32'(err_cnt - base_err), 32'd1);
        check("to_no_valid", 32'(valid_cnt - base_valid), 32'd0);
        rx_frame(8'h03, 16'h2211);
        check("to_next_channel", 32'(reward_channel), 32'd3);
        check("to_next_data", 32'(reward_data), 32'h2211);
        tick();

        // Byte on the timeout edge wins
        send_byte(8'h01);
        repeat (TO - 1) tick();
        base_err = err_cnt;
        send_byte(8'h11);
        check("to_edge_no_err", 32'(err), 32'd0);
        send_byte(8'h22);
`ifdef SERIAL_FRAME_CHECKSUM_EN
        send_byte(8'h32);
`endif
        check("to_edge_valid", 32'(reward_valid), 32'd1);
        check("to_edge_channel", 32'(reward_channel), 32'd1);
        check("to_edge_data", 32'(reward_data), 32'h2211);
        tick();
        check("to_edge_err_count", 32'(err_cnt - base_err), 32'd0);

        // Back-pressure: hold frame for 50 cycles
        reward_ready = 1'b0;
        rx_frame(8'h02, 16'h5678);
        check("hold_valid", 32'(reward_valid), 32'd1);
        rx_stb = 1'b1; rx_dat = 8'h99;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("hold_rx_rdy", 32'(rx_rdy), 32'd0);
            check("hold_valid_kept", 32'(reward_valid), 32'd1);
            check("hold_data", 32'(reward_data), 32'h5678);
        end
        rx_stb = 1'b0; rx_dat = 8'h00;
        reward_ready = 1'b1;
        tick();
        check("hold_release_rdy", 32'(rx_rdy), 32'd1);
        check("hold_release_valid", 32'(reward_valid), 32'd0);

`ifdef SERIAL_FRAME_CHECKSUM_EN
        // Checksum match and mismatch
        send_byte(8'h02); send_byte(8'h34); send_byte(8'h12); send_byte(8'h24);
        check("ck_ok_valid", 32'(reward_valid), 32'd1);
        check("ck_ok_data", 32'(reward_data), 32'h1234);
        tick();
        base_valid = valid_cnt;
        send_byte(8'h02); send_byte(8'h34); send_byte(8'h12); send_byte(8'h25);
        check("ck_bad_err", 32'(err), 32'd1);
        check("ck_bad_no_valid", 32'(reward_valid), 32'd0);
        tick();
        check("ck_bad_valid_count", 32'(valid_cnt - base_valid), 32'd0);
`endif

        // Reset mid-frame on both paths
        tx_rdy = 1'b0;
        action_valid = 1'b1; action_channel = 2'd2; action_data = 16'h1111;
        tick();
        action_valid = 1'b0;
        check("midrst_tx_started", 32'(tx_stb), 32'd1);
        send_byte(8'h02);
        rst = 1'b1;
        tick();
        check("midrst_tx_stb", 32'(tx_stb), 32'd0);
        check("midrst_rx_rdy", 32'(rx_rdy), 32'd0);
        check("midrst_action_ready", 32'(action_ready), 32'd0);
        rst = 1'b0;
        tx_rdy = 1'b1;
        tick();
        check("midrst_tx_abandoned", 32'(tx_stb), 32'd0);
        rx_frame(8'h01, 16'h3322);
        check("midrst_rx_channel", 32'(reward_channel), 32'd1);
        check("midrst_rx_data", 32'(reward_data), 32'h3322);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
